ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master.sv | 97 +++++++++
 tb/tb_ahb_cmd_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns simple command requests into single 32-bit AHB-Lite transfers
module ahb_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter bit         CHK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] ahb_m0_haddr_o,
  output logic        ahb_m0_hwrite_o,
  output logic [2:0]  ahb_m0_hsize_o,
  output logic [2:0]  ahb_m0_hburst_o,
  output logic [3:0]  ahb_m0_hprot_o,
  output logic [1:0]  ahb_m0_htrans_o,
  output logic        ahb_m0_hmastlock_o,
  output logic [31:0] ahb_m0_hwdata_o,
  input  logic        ahb_m0_hready_i,
  input  logic        ahb_m0_hresp_i,
  input  logic [31:0] ahb_m0_hrdata_i
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  state_t      state_q;
  logic [1:0]  htrans_q;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [31:0] wdata_q;
  logic [31:0] hwdata_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        misaligned;
  assign misaligned = CHK_ALIGN && (cmd_addr_i[1:0] != 2'b00);
  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign ahb_m0_haddr_o = haddr_q;
  assign ahb_m0_hwrite_o = hwrite_q;
  assign ahb_m0_hsize_o = 3'b010;
  assign ahb_m0_hburst_o = 3'b000;
  assign ahb_m0_hprot_o = HPROT_VAL;
  assign ahb_m0_htrans_o = htrans_q;
  assign ahb_m0_hmastlock_o = 1'b0;
  assign ahb_m0_hwdata_o = hwdata_q;
  // transfer sequencer: accept in IDLE, address phase in ADDR, data phase in DATA
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      wdata_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid_i) begin
          if (misaligned) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            haddr_q  <= cmd_addr_i;
            hwrite_q <= cmd_write_i;
            wdata_q  <= cmd_wdata_i;
            htrans_q <= HT_NONSEQ;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: if (ahb_m0_hready_i) begin
          htrans_q <= HT_IDLE;
          if (hwrite_q) hwdata_q <= wdata_q;
          state_q <= S_DATA;
        end
        S_DATA: if (ahb_m0_hready_i) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= ahb_m0_hresp_i;
          rsp_rdata_q <= hwrite_q ? 32'h0 : ahb_m0_hrdata_i;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed checks of the AHB command master
module tb_ahb_cmd_master;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  int n_cmp = 0;
  int n_fail = 0;
  int nonseq_cnt = 0;
  int rsp_cnt = 0;
  int ns0, rs0;

  ahb_cmd_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ahb_m0_haddr_o(haddr), .ahb_m0_hwrite_o(hwrite), .ahb_m0_hsize_o(hsize),
    .ahb_m0_hburst_o(hburst), .ahb_m0_hprot_o(hprot), .ahb_m0_htrans_o(htrans),
    .ahb_m0_hmastlock_o(hmastlock), .ahb_m0_hwdata_o(hwdata),
    .ahb_m0_hready_i(hready), .ahb_m0_hresp_i(hresp), .ahb_m0_hrdata_i(hrdata)
  );

  always #5 clk = ~clk;

  // bus activity monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (resetn && htrans == 2'b10 && hready) nonseq_cnt <= nonseq_cnt + 1;
    if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
  end

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("hprot", 32'(hprot), 32'h3);
    chk("hsize", 32'(hsize), 32'h2);
    chk("hburst", 32'(hburst), 32'h0);
    chk("hmastlock", 32'(hmastlock), 32'h0);
    step();
    resetn = 1'b1;
    step();
    // write, zero wait
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h4; cmd_wdata_i = 32'hDEAD_BEEF;
    step();
    cmd_valid_i = 1'b0;
    chk("wr_t1_htrans", 32'(htrans), 32'h2);
    chk("wr_t1_haddr", haddr, 32'h4);
    chk("wr_t1_hwrite", 32'(hwrite), 32'h1);
    chk("wr_t1_ready", 32'(cmd_ready_o), 32'h0);
    chk("wr_t1_rsp", 32'(rsp_valid_o), 32'h0);
    step();
    chk("wr_t2_htrans", 32'(htrans), 32'h0);
    chk("wr_t2_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("wr_t2_rsp", 32'(rsp_valid_o), 32'h0);
    step();
    chk("wr_t3_rsp", 32'(rsp_valid_o), 32'h1);
    chk("wr_t3_err", 32'(rsp_err_o), 32'h0);
    chk("wr_t3_rdata", rsp_rdata_o, 32'h0);
    chk("wr_t3_ready", 32'(cmd_ready_o), 32'h1);
    step();
    chk("wr_t4_rsp", 32'(rsp_valid_o), 32'h0);
    // read with one wait state in the address phase
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h20; hrdata = 32'h0;
    step();
    cmd_valid_i = 1'b0;
    chk("rd_t1_htrans", 32'(htrans), 32'h2);
    chk("rd_t1_hwrite", 32'(hwrite), 32'h0);
    hready = 1'b0;
    step();
    chk("rd_t2_htrans_held", 32'(htrans), 32'h2);
    chk("rd_t2_haddr_held", haddr, 32'h20);
    hready = 1'b1; hrdata = 32'h1234_5678;
    step();
    chk("rd_t3_htrans", 32'(htrans), 32'h0);
    chk("rd_t3_hwdata_kept", hwdata, 32'hDEAD_BEEF);
    chk("rd_t3_rsp", 32'(rsp_valid_o), 32'h0);
    step();
    hrdata = 32'h0;
    chk("rd_t4_rsp", 32'(rsp_valid_o), 32'h1);
    chk("rd_t4_rdata", rsp_rdata_o, 32'h1234_5678);
    chk("rd_t4_err", 32'(rsp_err_o), 32'h0);
    step();
    chk("rd_t5_rsp", 32'(rsp_valid_o), 32'h0);
    chk("rd_t5_rdata_hold", rsp_rdata_o, 32'h1234_5678);
    // misaligned command
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h6; cmd_wdata_i = 32'h1111_2222;
    step();
    cmd_valid_i = 1'b0;
    chk("mis_htrans", 32'(htrans), 32'h0);
    chk("mis_rsp", 32'(rsp_valid_o), 32'h1);
    chk("mis_err", 32'(rsp_err_o), 32'h1);
    chk("mis_rdata", rsp_rdata_o, 32'h0);
    chk("mis_ready", 32'(cmd_ready_o), 32'h1);
    step();
    chk("mis_rsp_end", 32'(rsp_valid_o), 32'h0);
    chk("mis_htrans_end", 32'(htrans), 32'h0);
    // two-cycle ERROR response
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h8;
    step();
    cmd_valid_i = 1'b0;
    chk("err_t1_htrans", 32'(htrans), 32'h2);
    step();
    chk("err_t2_htrans", 32'(htrans), 32'h0);
    hready = 1'b0; hresp = 1'b1;
    step();
    chk("err_t3_htrans", 32'(htrans), 32'h0);
    chk("err_t3_rsp", 32'(rsp_valid_o), 32'h0);
    chk("err_t3_ready", 32'(cmd_ready_o), 32'h0);
    hready = 1'b1;
    step();
    hresp = 1'b0;
    chk("err_t4_rsp", 32'(rsp_valid_o), 32'h1);
    chk("err_t4_err", 32'(rsp_err_o), 32'h1);
    chk("err_t4_htrans", 32'(htrans), 32'h0);
    step();
    chk("err_t5_rsp", 32'(rsp_valid_o), 32'h0);
    chk("err_t5_err_hold", 32'(rsp_err_o), 32'h1);
    // reset during a stalled data phase
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'hC;
    step();
    cmd_valid_i = 1'b0;
    step();
    hready = 1'b0;
    step();
    chk("rs_pre_ready", 32'(cmd_ready_o), 32'h0);
    chk("rs_pre_rsp", 32'(rsp_valid_o), 32'h0);
    rs0 = rsp_cnt;
    resetn = 1'b0;
    #2;
    chk("rs_htrans", 32'(htrans), 32'h0);
    chk("rs_haddr", haddr, 32'h0);
    chk("rs_hwrite", 32'(hwrite), 32'h0);
    chk("rs_hwdata", hwdata, 32'h0);
    chk("rs_err", 32'(rsp_err_o), 32'h0);
    chk("rs_rdata", rsp_rdata_o, 32'h0);
    chk("rs_ready", 32'(cmd_ready_o), 32'h1);
    step();
    hready = 1'b1;
    step();
    resetn = 1'b1;
    step();
    chk("rs_no_pulse", 32'(rsp_cnt - rs0), 32'h0);
    chk("rs_rel_ready", 32'(cmd_ready_o), 32'h1);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h10; hrdata = 32'hCAFE_F00D;
    step();
    cmd_valid_i = 1'b0;
    chk("rs_rd_htrans", 32'(htrans), 32'h2);
    chk("rs_rd_haddr", haddr, 32'h10);
    step();
    step();
    chk("rs_rd_rsp", 32'(rsp_valid_o), 32'h1);
    chk("rs_rd_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    step();
    // four back-to-back reads with cmd_valid held high
    ns0 = nonseq_cnt;
    rs0 = rsp_cnt;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_addr_i = 32'h100 + 32'(4 * k);
      hrdata = 32'hA000_0000 + 32'(k);
      step();
      chk("b2b_htrans", 32'(htrans), 32'h2);
      chk("b2b_haddr", haddr, 32'h100 + 32'(4 * k));
      chk("b2b_ready_addr", 32'(cmd_ready_o), 32'h0);
      step();
      chk("b2b_ready_data", 32'(cmd_ready_o), 32'h0);
      chk("b2b_rsp_early", 32'(rsp_valid_o), 32'h0);
      step();
      chk("b2b_rsp", 32'(rsp_valid_o), 32'h1);
      chk("b2b_rdata", rsp_rdata_o, 32'hA000_0000 + 32'(k));
      chk("b2b_ready_rsp", 32'(cmd_ready_o), 32'h1);
    end
    cmd_valid_i = 1'b0;
    step();
    step();
    chk("b2b_idle", 32'(htrans), 32'h0);
    chk("b2b_nonseq_cnt", 32'(nonseq_cnt - ns0), 32'd4);
    chk("b2b_rsp_cnt", 32'(rsp_cnt - rs0), 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
